// File: rtl/axi_write_arbiter_if.sv
// axi_write_arbiter_if: AXI4 write channels (AW, W, B) for one port, with master/slave views
interface axi_write_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16
);
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [7:0]            awlen;
  logic [2:0]            awsize;
  logic                  awvalid;
  logic                  awready;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  wlast;
  logic                  wvalid;
  logic                  wready;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;
  modport master (
    output awaddr, awlen, awsize, awvalid, wdata, wlast, wvalid, bready,
    input  awready, wready, bresp, bvalid
  );
  modport slave (
    input  awaddr, awlen, awsize, awvalid, wdata, wlast, wvalid, bready,
    output awready, wready, bresp, bvalid
  );
endinterface

// File: rtl/axi_write_arbiter.sv
// axi_write_arbiter: round-robin two-master AXI4 write arbiter, one AW/W/B transaction at a time
module axi_write_arbiter (
  input  logic                     aclk,
  input  logic                     areset,
  axi_write_arbiter_if.slave       m0,
  axi_write_arbiter_if.slave       m1,
  axi_write_arbiter_if.master      s,
  output logic [1:0]               grant,
  output logic                     last_err
);
  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;
  state_t     state, state_d;
  logic [1:0] grant_d;
  logic       pri, pri_d;
  logic [7:0] len_q, len_d, beat, beat_d;
  logic       sel, last;
  assign sel  = grant[1];
  assign last = beat == len_q;
  always_ff @(posedge aclk)
    if (areset) begin
      state <= IDLE;
      grant <= '0;
      pri   <= 1'b0;
      len_q <= '0;
      beat  <= '0;
    end else begin
      state <= state_d;
      grant <= grant_d;
      pri   <= pri_d;
      len_q <= len_d;
      beat  <= beat_d;
    end
  always_comb begin
    state_d    = state;
    grant_d    = grant;
    pri_d      = pri;
    len_d      = len_q;
    beat_d     = beat;
    last_err   = 1'b0;
    s.awaddr   = '0;
    s.awlen    = '0;
    s.awsize   = '0;
    s.awvalid  = 1'b0;
    s.wdata    = '0;
    s.wlast    = 1'b0;
    s.wvalid   = 1'b0;
    s.bready   = 1'b0;
    m0.awready = 1'b0;
    m1.awready = 1'b0;
    m0.wready  = 1'b0;
    m1.wready  = 1'b0;
    m0.bresp   = '0;
    m1.bresp   = '0;
    m0.bvalid  = 1'b0;
    m1.bvalid  = 1'b0;
    if (state == IDLE) begin
      // pri=1 means M1 holds priority on a tie
      if (m0.awvalid || m1.awvalid) begin
        grant_d = (m0.awvalid && !(m1.awvalid && pri)) ? 2'b01 : 2'b10;
        state_d = ADDR;
      end
    end else if (state == ADDR) begin
      s.awaddr   = sel ? m1.awaddr : m0.awaddr;
      s.awlen    = sel ? m1.awlen : m0.awlen;
      s.awsize   = sel ? m1.awsize : m0.awsize;
      s.awvalid  = sel ? m1.awvalid : m0.awvalid;
      m0.awready = !sel && s.awready;
      m1.awready = sel && s.awready;
      if (s.awvalid && s.awready) begin
        len_d   = s.awlen;
        beat_d  = '0;
        state_d = DATA;
      end
    end else if (state == DATA) begin
      s.wdata   = sel ? m1.wdata : m0.wdata;
      s.wvalid  = sel ? m1.wvalid : m0.wvalid;
      s.wlast   = last;
      m0.wready = !sel && s.wready;
      m1.wready = sel && s.wready;
      if (s.wvalid && s.wready) begin
        beat_d   = beat + 8'd1;
        last_err = (sel ? m1.wlast : m0.wlast) != last;
        if (last) state_d = RESP;
      end
    end else begin
      s.bready  = sel ? m1.bready : m0.bready;
      m0.bvalid = !sel && s.bvalid;
      m1.bvalid = sel && s.bvalid;
      m0.bresp  = sel ? 2'b00 : s.bresp;
      m1.bresp  = sel ? s.bresp : 2'b00;
      if (s.bvalid && s.bready) begin
        pri_d   = !sel;
        grant_d = '0;
        state_d = IDLE;
      end
    end
  end
endmodule

// File: tb/tb_axi_write_arbiter.sv
// tb_axi_write_arbiter: table-driven cycle vectors plus directed sequences for the write arbiter
module tb_axi_write_arbiter;
  logic       clk = 1'b0;
  logic       areset;
  logic [1:0] grant;
  logic       last_err;
  int         checks = 0;
  int         errors = 0;
  axi_write_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(16)) m0_if ();
  axi_write_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(16)) m1_if ();
  axi_write_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(16)) s_if ();
  axi_write_arbiter dut (
    .aclk(clk),
    .areset(areset),
    .m0(m0_if.slave),
    .m1(m1_if.slave),
    .s(s_if.master),
    .grant(grant),
    .last_err(last_err)
  );
  always #5 clk = ~clk;
  // ctl = {m0_aw, m0_w, m0_wl, m1_aw, m1_w, m1_wl}
  // exp = {grant, s_awv, s_wv, s_wlast, s_bready, awready{m1,m0}, wready{m1,m0}, bvalid{m1,m0}, last_err}
  typedef struct {
    logic [5:0]  ctl;
    logic [7:0]  len0;
    logic [7:0]  len1;
    logic [12:0] exp;
  } vec_t;
  vec_t vt [26];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", nm, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #2;
  endtask
  function automatic logic [12:0] obs();
    return {grant, s_if.awvalid, s_if.wvalid, s_if.wlast, s_if.bready,
            m1_if.awready, m0_if.awready, m1_if.wready, m0_if.wready,
            m1_if.bvalid, m0_if.bvalid, last_err};
  endfunction
  initial begin
    vt[0]  = '{6'b000_000, 8'd0, 8'd0, 13'b00_0000_00_00_00_0};
    vt[1]  = '{6'b100_100, 8'd1, 8'd1, 13'b00_0000_00_00_00_0};
    vt[2]  = '{6'b100_100, 8'd1, 8'd1, 13'b01_1000_01_00_00_0};
    vt[3]  = '{6'b010_100, 8'd1, 8'd1, 13'b01_0100_00_01_00_0};
    vt[4]  = '{6'b011_100, 8'd1, 8'd1, 13'b01_0110_00_01_00_0};
    vt[5]  = '{6'b000_100, 8'd1, 8'd1, 13'b01_0001_00_00_01_0};
    vt[6]  = '{6'b100_100, 8'd1, 8'd1, 13'b00_0000_00_00_00_0};
    vt[7]  = '{6'b100_100, 8'd1, 8'd1, 13'b10_1000_10_00_00_0};
    vt[8]  = '{6'b100_010, 8'd1, 8'd1, 13'b10_0100_00_10_00_0};
    vt[9]  = '{6'b100_011, 8'd1, 8'd1, 13'b10_0110_00_10_00_0};
    vt[10] = '{6'b000_000, 8'd1, 8'd1, 13'b10_0001_00_00_10_0};
    vt[11] = '{6'b100_000, 8'd3, 8'd0, 13'b00_0000_00_00_00_0};
    vt[12] = '{6'b100_000, 8'd3, 8'd0, 13'b01_1000_01_00_00_0};
    vt[13] = '{6'b010_000, 8'd3, 8'd0, 13'b01_0100_00_01_00_0};
    vt[14] = '{6'b010_000, 8'd3, 8'd0, 13'b01_0100_00_01_00_0};
    vt[15] = '{6'b000_000, 8'd3, 8'd0, 13'b01_0000_00_01_00_0};
    vt[16] = '{6'b010_000, 8'd3, 8'd0, 13'b01_0100_00_01_00_0};
    vt[17] = '{6'b011_000, 8'd3, 8'd0, 13'b01_0110_00_01_00_0};
    vt[18] = '{6'b000_000, 8'd3, 8'd0, 13'b01_0001_00_00_01_0};
    vt[19] = '{6'b000_000, 8'd3, 8'd0, 13'b00_0000_00_00_00_0};
    vt[20] = '{6'b100_000, 8'd2, 8'd0, 13'b00_0000_00_00_00_0};
    vt[21] = '{6'b100_000, 8'd2, 8'd0, 13'b01_1000_01_00_00_0};
    vt[22] = '{6'b010_000, 8'd2, 8'd0, 13'b01_0100_00_01_00_0};
    vt[23] = '{6'b011_000, 8'd2, 8'd0, 13'b01_0100_00_01_00_1};
    vt[24] = '{6'b011_000, 8'd2, 8'd0, 13'b01_0110_00_01_00_0};
    vt[25] = '{6'b000_000, 8'd2, 8'd0, 13'b01_0001_00_00_01_0};
    areset = 1'b1;
    m0_if.awaddr = 16'h0010; m0_if.awlen = '0; m0_if.awsize = 3'd2; m0_if.awvalid = 1'b0;
    m0_if.wdata = 32'hA0A0_0000; m0_if.wlast = 1'b0; m0_if.wvalid = 1'b0; m0_if.bready = 1'b1;
    m1_if.awaddr = 16'h0200; m1_if.awlen = '0; m1_if.awsize = 3'd2; m1_if.awvalid = 1'b0;
    m1_if.wdata = 32'hB1B1_0000; m1_if.wlast = 1'b0; m1_if.wvalid = 1'b0; m1_if.bready = 1'b1;
    s_if.awready = 1'b1; s_if.wready = 1'b1; s_if.bvalid = 1'b1; s_if.bresp = 2'b00;
    step();
    step();
    areset = 1'b0;
    #1;
    chk("rst_saddr", 32'(s_if.awaddr), 32'h0);
    chk("rst_m0bresp", 32'(m0_if.bresp), 32'h0);
    for (int i = 0; i < 26; i++) begin
      {m0_if.awvalid, m0_if.wvalid, m0_if.wlast, m1_if.awvalid, m1_if.wvalid, m1_if.wlast} = vt[i].ctl;
      m0_if.awlen = vt[i].len0;
      m1_if.awlen = vt[i].len1;
      #1;
      chk($sformatf("vec%0d", i), 32'(obs()), 32'(vt[i].exp));
      step();
    end
    // reset during beat 2 of an 8-beat M0 burst, with PRI pointing at M1 beforehand
    m0_if.awlen = 8'd7; m0_if.awvalid = 1'b1;
    step();
    #1;
    chk("rb_grant", 32'(grant), 32'h1);
    chk("rb_awaddr", 32'(s_if.awaddr), 32'h0010);
    chk("rb_awlen", 32'(s_if.awlen), 32'h7);
    step();
    m0_if.awvalid = 1'b0; m0_if.wvalid = 1'b1;
    step();
    step();
    #1;
    chk("rb_beat2", 32'({s_if.wvalid, s_if.wlast}), 32'b10);
    areset = 1'b1;
    step();
    areset = 1'b0; m0_if.wvalid = 1'b0;
    #1;
    chk("rb_idle", 32'({grant, s_if.awvalid, s_if.wvalid, s_if.bready, m0_if.wready, m0_if.bvalid}), 32'h0);
    m0_if.awvalid = 1'b1; m1_if.awvalid = 1'b1; m1_if.awlen = 8'd0;
    step();
    #1;
    chk("rb_pri_m0", 32'(grant), 32'h1);
    areset = 1'b1;
    step();
    areset = 1'b0; m0_if.awvalid = 1'b0;
    #1;
    chk("rb_idle2", 32'(grant), 32'h0);
    step();
    #1;
    chk("rb_m1_grant", 32'({grant, m1_if.awready}), 32'b101);
    step();
    m1_if.awvalid = 1'b0; m1_if.wvalid = 1'b1; m1_if.wlast = 1'b1;
    #1;
    chk("len0_wlast", 32'({s_if.wvalid, s_if.wlast, last_err}), 32'b110);
    step();
    m1_if.wvalid = 1'b0; m1_if.wlast = 1'b0;
    #1;
    chk("len0_bvalid", 32'(m1_if.bvalid), 32'h1);
    step();
    // M1 requests while M0 is mid-burst and must wait for the next IDLE
    m0_if.awlen = 8'd1; m0_if.awvalid = 1'b1;
    step();
    #1;
    chk("wait_grant0", 32'(grant), 32'h1);
    step();
    m0_if.awvalid = 1'b0; m0_if.wvalid = 1'b1; m1_if.awvalid = 1'b1; m1_if.awlen = 8'd0;
    #1;
    chk("wait_d0", 32'({m1_if.awready, m1_if.wready}), 32'h0);
    step();
    m0_if.wlast = 1'b1;
    #1;
    chk("wait_d1", 32'({m1_if.awready, m1_if.wready, s_if.wlast}), 32'b001);
    step();
    m0_if.wvalid = 1'b0; m0_if.wlast = 1'b0;
    #1;
    chk("wait_resp", 32'({grant, m1_if.awready, m0_if.bvalid}), 32'b0101);
    step();
    #1;
    chk("wait_idle", 32'({grant, m1_if.awready}), 32'h0);
    step();
    #1;
    chk("wait_grant1", 32'({grant, m1_if.awready, m0_if.awready}), 32'b1010);
    step();
    m1_if.awvalid = 1'b0; m1_if.wvalid = 1'b1; m1_if.wlast = 1'b1;
    step();
    m1_if.wvalid = 1'b0; m1_if.wlast = 1'b0;
    step();
    // error response held while M1 withholds BREADY
    s_if.bresp = 2'b10; m1_if.bready = 1'b0; m1_if.awaddr = 16'hFFF0; m1_if.awvalid = 1'b1;
    step();
    #1;
    chk("err_awaddr", 32'(s_if.awaddr), 32'hFFF0);
    step();
    m1_if.awvalid = 1'b0; m1_if.wvalid = 1'b1; m1_if.wlast = 1'b1;
    step();
    m1_if.wvalid = 1'b0; m1_if.wlast = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("err_hold%0d", k),
          32'({grant, m1_if.bvalid, m1_if.bresp, s_if.bready, m0_if.bvalid}), 32'b10_1_10_0_0);
      step();
    end
    m1_if.bready = 1'b1;
    #1;
    chk("err_accept", 32'({m1_if.bvalid, m1_if.bresp, s_if.bready, m0_if.bresp}), 32'b1_10_1_00);
    step();
    #1;
    chk("err_idle", 32'({grant, m1_if.bvalid, m1_if.bresp}), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/axi_write_arbiter.md
# axi_write_arbiter

Two-master AXI4 write-channel arbiter sharing the single write port of the memory-mapped slave. Grants one write transaction (AW, W burst, B) at a time with round-robin fairness. Generates S_WLAST from an internal beat counter and flags master WLAST mismatches. Sits between the two write requesters and the slave's AW/W/B channels; read channels bypass it.

## Interface
- DATA_WIDTH, 32, write data width
- ADDR_WIDTH, 16, address width
- ACLK  in  1  clock, all logic on rising edge
- ARESET  in  1  reset: one clock, synchronous, active-high
- M0_AWADDR / M1_AWADDR  in  ADDR_WIDTH  master write address
- M0_AWLEN / M1_AWLEN  in  8  burst length minus one
- M0_AWSIZE / M1_AWSIZE  in  3  beat size
- M0_AWVALID / M1_AWVALID  in  1  address valid
- M0_AWREADY / M1_AWREADY  out  1  address ready
- M0_WDATA / M1_WDATA  in  DATA_WIDTH  write data
- M0_WLAST / M1_WLAST  in  1  master last-beat marker
- M0_WVALID / M1_WVALID  in  1  data valid
- M0_WREADY / M1_WREADY  out  1  data ready
- M0_BRESP / M1_BRESP  out  2  write response
- M0_BVALID / M1_BVALID  out  1  response valid
- M0_BREADY / M1_BREADY  in  1  response ready
- S_AWADDR, S_AWLEN, S_AWSIZE, S_AWVALID  out  ADDR_WIDTH/8/3/1  to slave
- S_AWREADY  in  1  from slave
- S_WDATA, S_WLAST, S_WVALID  out  DATA_WIDTH/1/1  to slave
- S_WREADY  in  1  from slave
- S_BRESP, S_BVALID  in  2/1  from slave
- S_BREADY  out  1  to slave
- GRANT  out  2  one-hot owner (01=M0, 10=M1, 00=none)
- LAST_ERR  out  1  one-cycle pulse: master WLAST disagrees with beat count

## Operation
- States: IDLE, ADDR, DATA, RESP. Reset -> IDLE.
- IDLE:
  - If any Mx_AWVALID, select winner, register GRANT, go to ADDR.
  - Round-robin pointer PRI (reset = M0). Both requesting -> PRI master wins. One requesting -> that master wins.
- ADDR:
  - Granted master's AW signals muxed to S_AW*; S_AWREADY routed to its AWREADY.
  - On S_AWVALID&&S_AWREADY: latch AWLEN into len_q, clear beat counter, go to DATA.
  - Grant is held even if the master drops AWVALID.
- DATA:
  - Granted W muxed to slave; S_WREADY routed back.
  - S_WLAST = (beat == len_q), regardless of master WLAST.
  - Each W handshake increments beat (8-bit).
  - On the handshake with beat==len_q, go to RESP.
  - LAST_ERR pulses on any W handshake where Mx_WLAST != (beat==len_q).
- RESP:
  - S_BRESP/S_BVALID routed to granted master; its BREADY routed to S_BREADY.
  - On B handshake: PRI = other master, GRANT=00, go to IDLE.
- Non-granted master always sees AWREADY=WREADY=BVALID=0, BRESP=00.
- In IDLE all S_* valids and S_BREADY are 0; S_AWADDR/AWLEN/AWSIZE/WDATA are 0.

## Timing
- Reset values: state IDLE, GRANT=00, PRI=M0, LAST_ERR=0, all READY/VALID outputs 0, all M*_BRESP=00, S_* data outputs 0.
- ARESET mid-transaction: IDLE on the next edge, all valids/readies low, transaction abandoned, PRI back to M0.
- Arbitration latency: one cycle. AWVALID seen in IDLE at edge N -> S_AWVALID high after edge N.
- AW, W and B paths are combinational through the registered grant: zero added latency per handshake.
- Minimum transaction: 1 (arb) + 1 (AW) + (AWLEN+1) (W) + 1 (B) cycles with an always-ready slave.
- Next arbitration runs the cycle after the B handshake. No overlap between transactions.
- Request arriving during a transaction waits. It is evaluated in the next IDLE cycle.
- AWLEN=255: counter reaches 255 without wrap. AWLEN=0: single beat with S_WLAST=1.

## Test plan
- M0 alone, AWADDR=0x0010, AWLEN=3, slave always ready, BRESP=00:
  - GRANT=01 one cycle after AWVALID.
  - 4 W beats; S_WLAST only on beat 3.
  - M0 gets BRESP=00; then GRANT=00.
- M0 and M1 request in the same cycle, repeated twice:
  - First grant goes to M0, second to M1.
  - M1 never sees WREADY during the M0 burst.
- M1 asserts AWVALID during the M0 DATA phase:
  - M1_AWREADY stays 0 until M0's B handshake completes.
  - GRANT=10 the cycle after IDLE is re-entered.
- M0 AWLEN=2 asserts WLAST on beat 1:
  - LAST_ERR pulses on beat 1.
  - S_WLAST=1 only on beat 2; third beat is accepted; response is routed normally.
- Out-of-range address, slave returns BRESP=10, M1 BREADY held low 3 cycles:
  - M1_BVALID=1 with BRESP=10 held until BREADY.
  - Arbiter stays in RESP throughout.
- ARESET asserted for one cycle mid-burst (beat 2 of 8):
  - Next cycle: GRANT=00, all valids 0.
  - New M1 request is granted, since PRI resets to M0 and M0 is not requesting.
